imem_boot_loader: RTL

Boot-time sequencer for the 16-bit-word instruction memory. It accepts a length-prefixed, checksummed program image as a byte stream (from the UART/host link) and writes it word-by-word through the memory's write port. It then reads the image back through the registered-address read port to verify it. It holds the CPU until a verified image is present, and afterwards hands the read port to CPU instruction fetch.

---
 rtl/imem_boot_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image, writes it to
// instruction memory, reads it back to verify, then hands the read port to the CPU.
module imem_boot_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              run_start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [15:0]       mem_data,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_rdaddress,
  input  logic [15:0]       mem_q,
  input  logic [ADDR_W-1:0] cpu_rdaddress,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM_HI,
    S_CSUM_LO, S_VERIFY, S_DRAIN, S_CHECK, S_RUN, S_ERROR
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] len, len_m1, w_idx, rd_idx, len_in;
  logic [7:0]        hi_byte;
  logic [15:0]       word_in, csum, wr_sum, rd_sum;
  logic              accept;

  assign accept  = byte_valid && byte_ready;
  assign word_in = {hi_byte, byte_in};
  assign len_in  = ADDR_W'(word_in);
  assign len_m1  = len - ADDR_W'(1);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (load_start)     next_state = S_LEN_HI;
        else if (run_start) next_state = S_RUN;
      end
      S_LEN_HI:  if (accept) next_state = S_LEN_LO;
      S_LEN_LO:  if (accept) next_state = (len_in == '0) ? S_CSUM_HI : S_DATA_HI;
      S_DATA_HI: if (accept) next_state = S_DATA_LO;
      S_DATA_LO: if (accept) next_state = (w_idx == len_m1) ? S_CSUM_HI : S_DATA_HI;
      S_CSUM_HI: if (accept) next_state = S_CSUM_LO;
      S_CSUM_LO: if (accept) next_state = (len == '0) ? S_CHECK : S_VERIFY;
      S_VERIFY:  if (rd_idx == len_m1) next_state = S_DRAIN;
      S_DRAIN:   next_state = S_CHECK;
      S_CHECK:   next_state = (wr_sum == csum && rd_sum == csum) ? S_RUN : S_ERROR;
      S_RUN, S_ERROR: if (load_start) next_state = S_LEN_HI;
      default:   next_state = S_IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up exactly with state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byte_ready    <= 1'b0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      mem_wren      <= 1'b0;
      mem_wraddress <= '0;
      mem_data      <= '0;
      len           <= '0;
      w_idx         <= '0;
      rd_idx        <= '0;
      hi_byte       <= '0;
      csum          <= '0;
      wr_sum        <= '0;
      rd_sum        <= '0;
    end else begin
      byte_ready <= next_state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
                                       S_CSUM_HI, S_CSUM_LO};
      cpu_hold   <= (next_state != S_RUN);
      done       <= (next_state == S_RUN);
      error      <= (next_state == S_ERROR);
      mem_wren   <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (load_start) begin
            w_idx  <= '0;
            wr_sum <= '0;
            rd_sum <= '0;
          end
        end
        S_LEN_HI, S_DATA_HI, S_CSUM_HI: if (accept) hi_byte <= byte_in;
        S_LEN_LO: if (accept) len <= len_in;
        S_DATA_LO: begin
          if (accept) begin
            mem_wren      <= 1'b1;
            mem_wraddress <= w_idx;
            mem_data      <= word_in;
            wr_sum        <= wr_sum + word_in;
            w_idx         <= w_idx + ADDR_W'(1);
          end
        end
        S_CSUM_LO: begin
          if (accept) begin
            csum   <= word_in;
            rd_idx <= '0;
          end
        end
        S_VERIFY: begin
          // mem_q lags the address by one cycle, so the first VERIFY cycle has no data yet.
          rd_idx <= rd_idx + ADDR_W'(1);
          if (rd_idx != '0) rd_sum <= rd_sum + mem_q;
        end
        S_DRAIN: rd_sum <= rd_sum + mem_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rdaddress = '0;
    case (state)
      S_VERIFY, S_DRAIN: mem_rdaddress = rd_idx;
      S_RUN:             mem_rdaddress = cpu_rdaddress;
      default:           mem_rdaddress = '0;
    endcase
  end

endmodule
